// File: rtl/zuma_config_loader.sv
// zuma_config_loader
//   Streams a configuration image from a synchronous ROM into the ZUMA fabric
//   config port. A start pulse walks ROM addresses 0..DEPTH-1. Each returned
//   word goes out with its fabric address and a write strobe. The word is
//   bit-reversed when REVERSE is non-zero. An additive checksum of the raw ROM
//   words is compared with a reference value that is latched at start.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start           begin a load (accepted only in IDLE or DONE)
//   hold            suppress new ROM address issue while in LOAD
//   expected_sum    reference checksum, latched on accepted start
//   rom_addr        ROM read address (holds when nothing is issued)
//   rom_q           ROM data, valid ROM_LAT cycles after rom_addr
//   cfg_data/addr   registered fabric config word and address
//   cfg_en          registered fabric write strobe
//   busy, done      LOAD/DRAIN, DONE status
//   sum_ok          checksum match, meaningful while done=1
//   words_written   cfg_en pulses since the last accepted start
module zuma_config_loader #(
  parameter int unsigned     DATA_W  = 32,
  parameter int unsigned     ADDR_W  = 32,
  parameter longint unsigned DEPTH   = 1024,
  parameter int unsigned     ROM_LAT = 1,
  parameter int unsigned     REVERSE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  input  logic [DATA_W-1:0] expected_sum,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] cfg_data,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic              cfg_en,
  output logic              busy,
  output logic              done,
  output logic              sum_ok,
  output logic [ADDR_W-1:0] words_written
);

  // The issue counter carries one extra bit so that DEPTH = 2^ADDR_W can be
  // represented without wrapping before the last address.
  localparam logic [ADDR_W:0]   LAST_ISSUE = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = LAST_ISSUE[ADDR_W-1:0];

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] cfg_data_q;
  logic [ADDR_W-1:0] cfg_addr_q;
  logic              cfg_en_q;
  logic [ADDR_W-1:0] ww_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] exp_q;
  logic              sum_ok_q;

  // Stage 0 is aligned with rom_addr. Stage ROM_LAT is aligned with the rom_q
  // word that answers it.
  logic              pv_q [ROM_LAT+1];
  logic [ADDR_W-1:0] pa_q [ROM_LAT+1];

  logic              accept;
  logic              issue;
  logic [DATA_W-1:0] wr_data;

  function automatic logic [DATA_W-1:0] reverse_bits(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      r[DATA_W-1-i] = w[i];
    end
    return r;
  endfunction

  always_comb begin
    accept  = start && (state_q == IDLE || state_q == DONE);
    issue   = (state_q == LOAD) && !hold;
    wr_data = (REVERSE != 0) ? reverse_bits(rom_q) : rom_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD:       if (issue && cnt_q == LAST_ISSUE) state_d = DRAIN;
      DRAIN:      if (cfg_en_q && cfg_addr_q == LAST_ADDR) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      rom_addr_q <= '0;
      cfg_data_q <= '0;
      cfg_addr_q <= '0;
      cfg_en_q   <= 1'b0;
      ww_q       <= '0;
      acc_q      <= '0;
      exp_q      <= '0;
      sum_ok_q   <= 1'b0;
      for (int unsigned k = 0; k <= ROM_LAT; k++) begin
        pv_q[k] <= 1'b0;
        pa_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        acc_q    <= '0;
        ww_q     <= '0;
        exp_q    <= expected_sum;
        sum_ok_q <= 1'b0;
      end else if (state_q == DRAIN && state_d == DONE) begin
        sum_ok_q <= (acc_q == exp_q);
      end

      // Issue side: the pipeline shifts every cycle, so words already in
      // flight still complete while hold is high.
      pv_q[0] <= issue;
      if (issue) begin
        rom_addr_q <= cnt_q[ADDR_W-1:0];
        pa_q[0]    <= cnt_q[ADDR_W-1:0];
        cnt_q      <= cnt_q + 1'b1;
      end
      for (int unsigned k = 1; k <= ROM_LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        pa_q[k] <= pa_q[k-1];
      end

      // Write side
      cfg_en_q <= pv_q[ROM_LAT];
      if (pv_q[ROM_LAT]) begin
        cfg_data_q <= wr_data;
        cfg_addr_q <= pa_q[ROM_LAT];
        ww_q       <= ww_q + 1'b1;
        acc_q      <= acc_q + rom_q;
      end
    end
  end

  assign rom_addr      = rom_addr_q;
  assign cfg_data      = cfg_data_q;
  assign cfg_addr      = cfg_addr_q;
  assign cfg_en        = cfg_en_q;
  assign busy          = (state_q == LOAD) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign sum_ok        = sum_ok_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_zuma_config_loader.sv
module tb_zuma_config_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic        hold;
  logic [31:0] expected_sum;

  // Instance 0: DEPTH=8 ROM_LAT=1 REVERSE=1
  // Instance 1: DEPTH=8 ROM_LAT=3 REVERSE=0
  // Instance 2: DEPTH=1 ROM_LAT=1 REVERSE=0
  logic [31:0] ra   [3];
  logic [31:0] rq   [3];
  logic [31:0] cd   [3];
  logic [31:0] ca   [3];
  logic        ce   [3];
  logic        bz   [3];
  logic        dn   [3];
  logic        ok   [3];
  logic [31:0] ww   [3];

  logic [31:0] rom  [3][8];
  logic [31:0] r0_1, r1_1, r1_2, r1_3, r2_1;

  int unsigned sel;
  logic [31:0] o_ra, o_data, o_addr, o_ww;
  logic        o_en, o_busy, o_done, o_ok;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [31:0] ra_model [3];

  always #5 clk = ~clk;

  zuma_config_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(8), .ROM_LAT(1), .REVERSE(1)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .hold(hold), .expected_sum(expected_sum),
    .rom_addr(ra[0]), .rom_q(rq[0]), .cfg_data(cd[0]), .cfg_addr(ca[0]), .cfg_en(ce[0]),
    .busy(bz[0]), .done(dn[0]), .sum_ok(ok[0]), .words_written(ww[0]));

  zuma_config_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(8), .ROM_LAT(3), .REVERSE(0)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .hold(hold), .expected_sum(expected_sum),
    .rom_addr(ra[1]), .rom_q(rq[1]), .cfg_data(cd[1]), .cfg_addr(ca[1]), .cfg_en(ce[1]),
    .busy(bz[1]), .done(dn[1]), .sum_ok(ok[1]), .words_written(ww[1]));

  zuma_config_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(1), .ROM_LAT(1), .REVERSE(0)) u_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .hold(hold), .expected_sum(expected_sum),
    .rom_addr(ra[2]), .rom_q(rq[2]), .cfg_data(cd[2]), .cfg_addr(ca[2]), .cfg_en(ce[2]),
    .busy(bz[2]), .done(dn[2]), .sum_ok(ok[2]), .words_written(ww[2]));

  // Synchronous ROM models with the matching read latency
  always @(posedge clk) begin
    r0_1 <= rom[0][ra[0][2:0]];
    r1_1 <= rom[1][ra[1][2:0]];
    r1_2 <= r1_1;
    r1_3 <= r1_2;
    r2_1 <= rom[2][ra[2][2:0]];
  end
  assign rq[0] = r0_1;
  assign rq[1] = r1_3;
  assign rq[2] = r2_1;

  always_comb begin
    o_ra   = ra[sel];
    o_data = cd[sel];
    o_addr = ca[sel];
    o_ww   = ww[sel];
    o_en   = ce[sel];
    o_busy = bz[sel];
    o_done = dn[sel];
    o_ok   = ok[sel];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom_sum(input int unsigned inst, input int unsigned d);
    logic [31:0] s;
    s = 0;
    for (int unsigned i = 0; i < d; i++) s = s + rom[inst][i];
    return s;
  endfunction

  function automatic int unsigned depth_of(input int unsigned inst);
    return (inst == 2) ? 1 : 8;
  endfunction

  // Drives one load on instance inst and checks it cycle by cycle.
  // hmode: 0 no hold, 1 directed hold pattern, 2 random hold.
  task automatic run_load(input int unsigned inst, input int unsigned hmode,
                          input logic [31:0] esum, input bit inject,
                          input int unsigned abort_n);
    int unsigned d, lat, issued, wr, done_edge, last_issue;
    bit          rev, finished, h;
    bit          en_exp [0:199];
    logic [31:0] sum, w, wexp;
    d = depth_of(inst);
    lat = (inst == 1) ? 3 : 1;
    rev = (inst == 0);
    sum = rom_sum(inst, d);
    issued = 0; wr = 0; done_edge = 1000; last_issue = 0; finished = 0;
    for (int i = 0; i < 200; i++) en_exp[i] = 0;
    sel = inst;
    hold = 1'b0;
    expected_sum = esum;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    for (int unsigned k = 1; k <= 150 && !finished; k++) begin
      case (hmode)
        0:       h = 0;
        1:       h = (k >= 3 && k <= 5) || (issued == 7 && last_issue == k - 1);
        default: h = ($urandom_range(0, 3) == 0);
      endcase
      hold = h;
      if (inject && k == 4) begin
        start_v[inst] = 1'b1;
        expected_sum = ~esum;
      end
      @(posedge clk); #1;
      start_v = '0;
      expected_sum = esum;
      if (!h && issued < d) begin
        ra_model[inst] = issued;
        issued++;
        last_issue = k;
        en_exp[k + 1 + lat] = 1;
        if (issued == d) done_edge = k + 2 + lat;
      end
      chk("cfg_en", 32'(o_en), 32'(en_exp[k]));
      chk("rom_addr", o_ra, ra_model[inst]);
      chk("busy", 32'(o_busy), 32'(k < done_edge));
      chk("done", 32'(o_done), 32'(k >= done_edge));
      if (k == 1) begin
        chk("sum_ok_cleared", 32'(o_ok), 32'd0);
        chk("ww_cleared", o_ww, 32'd0);
      end
      if (o_en === 1'b1) begin
        w = rom[inst][wr];
        wexp = rev ? {<<{w}} : w;
        chk("cfg_addr", o_addr, wr);
        chk("cfg_data", o_data, wexp);
        chk("words_written", o_ww, wr + 1);
        wr++;
      end
      if (abort_n != 0 && wr == abort_n) begin
        reset = 1'b1;
        hold = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_cfg_en", 32'(o_en), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_ww", o_ww, 32'd0);
        for (int i = 0; i < 3; i++) ra_model[i] = 0;
        return;
      end
      if (k == done_edge) finished = 1;
    end
    hold = 1'b0;
    chk("load_finished", 32'(finished), 32'd1);
    chk("sum_ok", 32'(o_ok), 32'(sum == esum));
    chk("final_ww", o_ww, d);
    chk("write_count", wr, d);
  endtask

  initial begin
    logic [31:0] s;
    int unsigned inst;
    reset = 1'b1;
    start_v = '0;
    hold = 1'b0;
    expected_sum = '0;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      ra_model[i] = 0;
      for (int j = 0; j < 8; j++) rom[i][j] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("rst_rom_addr", o_ra, 32'd0);
      chk("rst_cfg_data", o_data, 32'd0);
      chk("rst_cfg_addr", o_addr, 32'd0);
      chk("rst_ww", o_ww, 32'd0);
      chk("rst_flags", {28'd0, o_en, o_busy, o_done, o_ok}, 32'd0);
    end
    @(posedge clk); #1;

    // Ramp image through the reversing instance: sum 28 matches, then 27 fails
    for (int j = 0; j < 8; j++) rom[0][j] = j;
    run_load(0, 0, 32'd28, 0, 0);
    run_load(0, 0, 32'd27, 0, 0);

    // Latency-3 instance with the directed hold pattern
    for (int j = 0; j < 8; j++) rom[1][j] = j;
    run_load(1, 1, 32'd28, 0, 0);

    // Abort on the fourth write, then a clean full load
    for (int j = 0; j < 8; j++) rom[0][j] = $urandom;
    s = rom_sum(0, 8);
    run_load(0, 0, s, 0, 4);
    run_load(0, 0, s, 0, 0);

    // Single-word image
    rom[2][0] = 32'hDEADBEEF;
    run_load(2, 0, 32'hDEADBEEF, 0, 0);

    // start during LOAD must be ignored
    for (int j = 0; j < 8; j++) rom[1][j] = $urandom;
    run_load(1, 2, rom_sum(1, 8), 1, 0);

    // Randomized loads across all instances
    for (int it = 0; it < 8; it++) begin
      inst = $urandom_range(0, 2);
      for (int j = 0; j < 8; j++) rom[inst][j] = $urandom;
      s = rom_sum(inst, depth_of(inst)) + 32'($urandom_range(0, 1));
      run_load(inst, 2, s, 1'($urandom_range(0, 1)), 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/zuma_config_loader.md
Name: zuma_config_loader

Overview:
- Parametrised configuration streamer for the ZUMA overlay, one level above the generated fabric.
- On a start pulse it walks a synchronous config ROM from address 0 to DEPTH-1 and presents each word, optionally bit-reversed, with its fabric address and a write strobe on the fabric config port.
- Tolerates configurable ROM read latency and supports issue stalls.
- Computes an additive checksum over the stream and reports pass/fail against an expected value.

Parameters:
- DATA_W, 32, config word width.
- ADDR_W, 32, width of ROM and fabric config addresses.
- DEPTH, 1024, number of config words per load; range 1..2^ADDR_W.
- ROM_LAT, 1, ROM read latency in cycles from rom_addr to rom_q; range 1..4.
- REVERSE, 1, 1 = cfg_data[DATA_W-1-i] = rom_q[i]; 0 = pass-through.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE
- hold  in  1  while high, no new ROM address is issued
- expected_sum  in  DATA_W  reference checksum, sampled on accepted start
- rom_addr  out  ADDR_W  ROM read address
- rom_q  in  DATA_W  ROM data, valid ROM_LAT cycles after rom_addr
- cfg_data  out  DATA_W  word to fabric, registered
- cfg_addr  out  ADDR_W  fabric config address, registered
- cfg_en  out  1  fabric write strobe, registered
- busy  out  1  high in LOAD or DRAIN
- done  out  1  high in DONE
- sum_ok  out  1  checksum match; valid only while done=1
- words_written  out  ADDR_W  count of cfg_en pulses since accepted start (progress)

Behaviour:
- Reset values: state IDLE; rom_addr, cfg_data, cfg_addr, words_written = 0; cfg_en, busy, done, sum_ok = 0. Checksum accumulator, issue counter and valid pipeline are cleared.
- Reset during LOAD or DRAIN aborts the load. cfg_en is 0 from the cycle after reset is sampled. In-flight ROM reads are discarded.
- FSM:
  - IDLE: on start, enter LOAD. Clear the counters and accumulator, latch expected_sum.
  - LOAD: each cycle with hold=0, issue rom_addr = issue count and push a valid bit plus that address into a ROM_LAT-deep shift pipeline, then increment the issue count. After address DEPTH-1 is issued, go to DRAIN. With hold=1, issue nothing; the pipeline keeps advancing, so in-flight words still complete.
  - DRAIN: go to DONE on the cycle the last write (address DEPTH-1) is registered.
  - DONE: hold outputs. start re-enters LOAD exactly as from IDLE.
  - start during LOAD or DRAIN is ignored.
- rom_addr holds its last value when no address is issued.
- Write path: when a pipeline entry emerges valid, on the next edge:
  - cfg_data is loaded with the optionally reversed rom_q;
  - cfg_addr is loaded with the carried address;
  - cfg_en is set to 1;
  - words_written is incremented;
  - the accumulator is updated: acc = acc + rom_q (pre-reversal), mod 2^DATA_W.
- Otherwise cfg_en=0 and cfg_data/cfg_addr hold.
- Latency: start accepted at edge N → first rom_addr issued in cycle N+1 → first cfg_en=1 in cycle N+2+ROM_LAT. With hold=0 throughout, cfg_en is high for exactly DEPTH consecutive cycles, and done rises the cycle after the last cfg_en.
- Addresses are written strictly in order 0..DEPTH-1, each exactly once, with no gaps in address and none skipped under any hold pattern.
- sum_ok = (acc == latched expected_sum); it is evaluated when entering DONE and cleared when start is accepted.
- DEPTH=1: a single issue goes straight to DRAIN; exactly one write, at cfg_addr=0.
- The issue counter is ADDR_W+1 bits wide internally, so DEPTH=2^ADDR_W does not wrap prematurely.
- hold is ignored outside LOAD.

Test Plan:
- DEPTH=8, ROM_LAT=1, REVERSE=1, rom[a]=a, expected_sum=28, start once, hold=0 → cfg_en high for 8 consecutive cycles beginning 3 cycles after start; cfg_addr 0..7; cfg_data for a=1 is 0x80000000; done=1 the cycle after; sum_ok=1; words_written=8.
- Same setup with expected_sum=27 → identical write stream; done=1, sum_ok=0.
- ROM_LAT=3, hold high for cycles 3-5 after start and again on the cycle after address 6 is issued → every address 0..7 written once in order; cfg_en gaps appear only due to hold; sum_ok=1.
- Reset asserted on the 4th cfg_en cycle → cfg_en=0, busy=0, words_written=0 next cycle. A following start produces a full, correct 8-word load.
- DEPTH=1, REVERSE=0, rom[0]=0xDEADBEEF, expected_sum=0xDEADBEEF → single write cfg_addr=0, cfg_data=0xDEADBEEF; sum_ok=1.
- start pulsed during LOAD → ignored (no restart, addresses continue). start pulsed in DONE → new load begins, sum_ok cleared, words_written restarts at 0.
